lsu_arbiter: RTL

//  Shares the single LSU load/store port (VALID/READY handshake, 32-bit addr/data, 4-bit strobe)

---
 rtl/singlecycle_pkg.sv | 5 +
 rtl/lsu_rr_pick.sv | 25 ++
 rtl/lsu_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/singlecycle_pkg.sv
// singlecycle_pkg: shared types and defaults for the LSU port arbiter.
package singlecycle_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  localparam int LSU_ARB_TIMEOUT_DEF = 255;
endpackage

// File: rtl/lsu_rr_pick.sv
// lsu_rr_pick: combinational round-robin pick of the first valid request after i_last.
module lsu_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last,
  output logic [$clog2(NUM_REQ)-1:0] o_grant,
  output logic                       o_any
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] idx;
  // Walk from the farthest offset down so the nearest requester after i_last wins.
  always_comb begin
    o_grant = '0;
    o_any = 1'b0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(i_last) + i) % NUM_REQ);
      if (i_req[idx]) begin
        o_grant = idx;
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin share of the single LSU port among NUM_REQ requesters.
// Define LSU_ARB_TIMEOUT_EN to force an error completion after TIMEOUT_CYC stalled BUSY cycles.
module lsu_arbiter
  import singlecycle_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = LSU_ARB_TIMEOUT_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_vld,
  input  logic [NUM_REQ-1:0][31:0]  i_req_addr,
  input  logic [NUM_REQ-1:0][31:0]  i_req_wdata,
  input  logic [NUM_REQ-1:0][3:0]   i_req_strb,
  input  logic [NUM_REQ-1:0]        i_req_wren,
  output logic [NUM_REQ-1:0]        o_req_rdy,
  output logic [NUM_REQ-1:0]        o_req_err,
  output logic [31:0]               o_req_rdata,
  output logic                      o_lsu_vld,
  output logic [31:0]               o_lsu_addr,
  output logic [31:0]               o_lsu_st_data,
  output logic [3:0]                o_lsu_st_strb,
  output logic                      o_lsu_wren,
  input  logic                      i_lsu_ready,
  input  logic [31:0]               i_lsu_ld_data
);
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("lsu_arbiter: unsupported NUM_REQ/TIMEOUT_CYC");
  end

  arb_state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick, sel;
  logic [NUM_REQ-1:0] rdy_v, err_v;
  logic any, busy, vld, done, to, on;
`ifdef LSU_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  lsu_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req   (i_req_vld),
    .i_last  (last_q),
    .o_grant (pick),
    .o_any   (any)
  );

  always_comb begin
    busy = state_q == ARB_BUSY;
    sel = busy ? grant_q : pick;
    vld = busy ? i_req_vld[grant_q] : any;
    done = vld & i_lsu_ready;
`ifdef LSU_ARB_TIMEOUT_EN
    cnt_d = busy ? cnt_q + 1'b1 : '0;
    to = busy & vld & ~i_lsu_ready & (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
    to = 1'b0;
`endif
    rdy_v = '0;
    rdy_v[sel] = done | to;
    err_v = '0;
    err_v[sel] = to;
    last_d = (done | to) ? sel : last_q;
    grant_d = (!busy && any) ? pick : grant_q;
    // A locked requester dropping vld abandons the transfer without a completion.
    state_d = (done | to | (busy & ~vld)) ? ARB_IDLE : (any ? ARB_BUSY : state_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
    end
  end

`ifdef LSU_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif

  assign on = vld & i_rst_n;
  assign o_lsu_vld = on;
  assign o_lsu_addr = on ? i_req_addr[sel] : '0;
  assign o_lsu_st_data = on ? i_req_wdata[sel] : '0;
  assign o_lsu_st_strb = on ? i_req_strb[sel] : '0;
  assign o_lsu_wren = on & i_req_wren[sel];
  assign o_req_rdy = i_rst_n ? rdy_v : '0;
  assign o_req_err = i_rst_n ? err_v : '0;
  assign o_req_rdata = (done & i_rst_n) ? i_lsu_ld_data : '0;
endmodule
